// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data
// load/store. One access in flight at a time, sequenced IDLE -> ISSUE ->
// (WAIT) -> RESP. Data has priority; a starvation counter bounds how many
// consecutive data grants can be taken while fetch is waiting.
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  // fetch requester (read only)
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_ack_o,
  output logic [DW-1:0] if_rdata_o,
  // data requester
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic          d_ack_o,
  output logic [DW-1:0] d_rdata_o,
  // memory port
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  // status
  output logic          busy_o,
  output logic          owner_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [3:0] LatInit   = 4'(MEM_LAT - 1);
  localparam logic [2:0] StarveMax = 3'(STARVE_MAX);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    lat_cnt_q, lat_cnt_d;
  logic [2:0]    starve_q, starve_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic          busy_q, busy_d;
  logic          d_win;

  // Data wins unless fetch is also waiting and has hit the starvation limit.
  assign d_win = d_req_i && !(if_req_i && (starve_q == StarveMax));

  // Next-state, arbitration and registered-output decode.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_cnt_d  = lat_cnt_q;
    starve_d   = starve_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (if_req_i || d_req_i) begin
          if (d_win) begin
            owner_d = 1'b1;
            we_d    = d_we_i;
            addr_d  = d_addr_i;
            if (if_req_i && (starve_q != StarveMax)) begin
              starve_d = starve_q + 3'd1;
            end
          end else begin
            owner_d  = 1'b0;
            we_d     = 1'b0;
            addr_d   = if_addr_i;
            starve_d = '0;
          end
          wdata_d = d_wdata_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d = StResp;
        end else begin
          lat_cnt_d = LatInit;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (lat_cnt_q == '0) begin
          if (owner_q) begin
            d_rdata_d = mem_rdata_i;
          end else begin
            if_rdata_d = mem_rdata_i;
          end
          state_d = StResp;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are decoded from the next state so they are pure flops.
    mem_en_d = (state_d == StIssue);
    mem_we_d = (state_d == StIssue) && we_d;
    busy_d   = (state_d != StIdle);
    if_ack_d = (state_d == StResp) && !owner_d;
    d_ack_d  = (state_d == StResp) && owner_d;
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_cnt_q  <= '0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_cnt_q  <= lat_cnt_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
    end
  end

  assign if_ack_o    = if_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_ack_o     = d_ack_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: randomized requesters and a memory model, with
// a transaction-timeline reference model checked every cycle.
module tb_mem_port_arbiter;

  localparam int unsigned AW        = 32;
  localparam int unsigned DW        = 32;
  localparam int          MemLat    = 2;
  localparam int          StarveMax = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          if_ack, d_ack, mem_en, mem_we, busy, owner;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  mem_port_arbiter #(
    .AW        (AW),
    .DW        (DW),
    .MEM_LAT   (MemLat),
    .STARVE_MAX(StarveMax)
  ) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_ack_o   (if_ack),
    .if_rdata_o (if_rdata),
    .d_req_i    (d_req),
    .d_we_i     (d_we),
    .d_addr_i   (d_addr),
    .d_wdata_i  (d_wdata),
    .d_ack_o    (d_ack),
    .d_rdata_o  (d_rdata),
    .mem_en_o   (mem_en),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .busy_o     (busy),
    .owner_o    (owner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: one transaction timeline plus the starvation count.
  logic [31:0] mem [64];
  bit          in_rst;
  bit          have;
  int          t_issue, t_resp, next_sample;
  bit          m_owner, m_we;
  logic [31:0] m_addr, m_wdata, rd_val, exp_ird, exp_drd;
  int          starve;

  // Requester behaviour (percent chances) and observation hooks.
  int if_start, if_keep, d_start, d_keep;
  bit rec_en;
  int rec_q[$];
  int last_en, lat_if, lat_d;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(63)) << 2;
    return a;
  endfunction

  task automatic do_cycle();
    bit dwin, e_en, e_ia, e_da;
    @(posedge clk);
    cyc++;
    if (!in_rst && cyc >= next_sample && (if_req || d_req)) begin
      dwin    = d_req && !(if_req && starve == StarveMax);
      m_owner = dwin;
      m_we    = dwin && d_we;
      m_addr  = dwin ? d_addr : if_addr;
      m_wdata = d_wdata;
      if (dwin) begin
        if (if_req && starve < StarveMax) starve++;
      end else begin
        starve = 0;
      end
      if (m_we) mem[m_addr[7:2]] = m_wdata;
      rd_val      = mem[m_addr[7:2]];
      have        = 1'b1;
      t_issue     = cyc;
      t_resp      = cyc + (m_we ? 1 : MemLat + 1);
      next_sample = t_resp + 2;
    end
    @(negedge clk);
    e_en = have && cyc == t_issue;
    e_ia = have && cyc == t_resp && !m_owner;
    e_da = have && cyc == t_resp && m_owner;
    if (have && cyc == t_resp && !m_we) begin
      if (m_owner) exp_drd = rd_val;
      else exp_ird = rd_val;
    end
    check_eq("mem_en", mem_en, e_en);
    check_eq("mem_we", mem_we, e_en && m_we);
    check_eq("mem_addr", mem_addr, m_addr);
    if (e_en && m_we) check_eq("mem_wdata", mem_wdata, m_wdata);
    check_eq("busy", busy, have && cyc >= t_issue && cyc <= t_resp);
    check_eq("owner", owner, m_owner);
    check_eq("if_ack", if_ack, e_ia);
    check_eq("d_ack", d_ack, e_da);
    check_eq("if_rdata", if_rdata, exp_ird);
    check_eq("d_rdata", d_rdata, exp_drd);
    if (mem_en) begin
      last_en = cyc;
      if (rec_en) rec_q.push_back(int'(owner));
    end
    if (if_ack) lat_if = cyc - last_en;
    if (d_ack) lat_d = cyc - last_en;
    // Read data is only valid in the final latency cycle; junk elsewhere.
    mem_rdata = (have && !m_we && cyc == t_issue + MemLat) ? rd_val : $urandom;
    if (if_req) begin
      if (e_ia) begin
        if (int'($urandom_range(99)) < if_keep) if_addr = rand_addr();
        else if_req = 1'b0;
      end
    end else if (int'($urandom_range(99)) < if_start) begin
      if_req  = 1'b1;
      if_addr = rand_addr();
    end
    if (d_req) begin
      if (e_da) begin
        if (int'($urandom_range(99)) < d_keep) begin
          d_we = 1'($urandom_range(1)); d_addr = rand_addr(); d_wdata = $urandom;
        end else begin
          d_req = 1'b0;
        end
      end
    end else if (int'($urandom_range(99)) < d_start) begin
      d_req = 1'b1; d_we = 1'($urandom_range(1)); d_addr = rand_addr(); d_wdata = $urandom;
    end
  endtask

  task automatic assert_reset();
    rst_n = 1'b0; in_rst = 1'b1;
    have = 1'b0; starve = 0; m_owner = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; exp_ird = '0; exp_drd = '0;
    #1;
    check_eq("rst_if_ack", if_ack, 0);
    check_eq("rst_d_ack", d_ack, 0);
    check_eq("rst_if_rdata", if_rdata, 0);
    check_eq("rst_d_rdata", d_rdata, 0);
    check_eq("rst_mem_en", mem_en, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_owner", owner, 0);
  endtask

  task automatic release_reset();
    rst_n = 1'b1; in_rst = 1'b0; next_sample = cyc + 1;
  endtask

  task automatic quiesce();
    if_start = 0; if_keep = 0; d_start = 0; d_keep = 0; rec_en = 1'b0;
    repeat (16) do_cycle();
  endtask

  int pat[6] = '{1, 1, 0, 1, 1, 0};

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[16] = 32'h8C22_0004;
    rst_n = 1'b1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    if_start = 0; if_keep = 0; d_start = 0; d_keep = 0; rec_en = 0;
    next_sample = 0; last_en = 0; lat_if = -1; lat_d = -1;
    #2;
    assert_reset();
    repeat (2) do_cycle();
    release_reset();
    repeat (2) do_cycle();

    // Single fetch
    lat_if = -1; lat_d = -1;
    if_req = 1'b1; if_addr = 32'h40;
    repeat (10) do_cycle();
    check_eq("fetch_ack_lat", lat_if, MemLat + 1);
    check_eq("fetch_rdata", if_rdata, 32'h8C22_0004);
    check_eq("fetch_no_dack", lat_d, -1);

    // Store
    lat_d = -1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    repeat (8) do_cycle();
    check_eq("store_ack_lat", lat_d, 1);
    check_eq("store_d_rdata", d_rdata, 0);
    check_eq("store_busy_low", busy, 0);

    // Load with req dropped during WAIT
    lat_d = -1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    do_cycle();
    do_cycle();
    d_req = 1'b0;
    repeat (8) do_cycle();
    check_eq("drop_ack_lat", lat_d, MemLat + 1);
    check_eq("drop_rdata", d_rdata, 32'h8C22_0004);

    // Continuous contention
    rec_q.delete(); rec_en = 1'b1;
    if_start = 100; if_keep = 100; d_start = 100; d_keep = 100;
    if_req = 1'b1; if_addr = rand_addr();
    d_req = 1'b1; d_we = 1'($urandom_range(1)); d_addr = rand_addr(); d_wdata = $urandom;
    repeat (36) do_cycle();
    check_eq("contend_grants", rec_q.size() >= 6, 1);
    for (int i = 0; i < 6; i++) begin
      if (i < rec_q.size()) check_eq($sformatf("contend_grant%0d", i), rec_q[i], pat[i]);
    end
    quiesce();

    // Data only, then a late fetch request
    rec_q.delete(); rec_en = 1'b1; d_start = 100; d_keep = 100;
    d_req = 1'b1; d_we = 1'($urandom_range(1)); d_addr = rand_addr(); d_wdata = $urandom;
    repeat (28) do_cycle();
    check_eq("donly_grants", rec_q.size() >= 5, 1);
    for (int i = 0; i < rec_q.size(); i++) check_eq("donly_owner", rec_q[i], 1);
    rec_q.delete();
    if_req = 1'b1; if_addr = rand_addr();
    repeat (8) do_cycle();
    check_eq("late_fetch_seen", rec_q.size() >= 1, 1);
    if (rec_q.size() >= 1) check_eq("late_fetch_loses", rec_q[0], 1);
    quiesce();

    // Random traffic
    if_start = 40; if_keep = 50; d_start = 40; d_keep = 50;
    repeat (600) do_cycle();
    quiesce();

    // Reset during WAIT, then a fresh fetch
    if_req = 1'b1; if_addr = 32'h44;
    do_cycle();
    do_cycle();
    if_req = 1'b0;
    assert_reset();
    do_cycle();
    release_reset();
    lat_if = -1;
    if_req = 1'b1; if_addr = 32'h40;
    repeat (8) do_cycle();
    check_eq("post_rst_lat", lat_if, MemLat + 1);
    check_eq("post_rst_rdata", if_rdata, 32'h8C22_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
